seven_segment_scanner: RTL

Parametrised multiplexed hex display driver for common-anode seven-segment banks. It generalises the fixed 4-digit switch display in three ways: a configurable digit count, a built-in refresh timer, and tear-free value loading. It also adds per-digit decimal points, optional leading-zero blanking, PWM brightness control and a frame-complete strobe. It sits directly between the board top and the anode/cathode pins, replacing the separate divider/counter/mux/decoder chain.

---
 rtl/seven_segment_scanner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed hex driver for common-anode seven-segment banks with refresh timer,
// frame-aligned double buffering, leading-zero blanking and PWM brightness.
module seven_segment_scanner #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BRIGHT_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*DIGITS-1:0]     value,
  input  logic [DIGITS-1:0]       dp,
  input  logic                    load,
  input  logic                    blank_leading_zeros,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic [DIGITS-1:0]       anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PreMax = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BRIGHT_WIDTH-1:0] pwm_q, pwm_d;
  logic [4*DIGITS-1:0]     pend_val_q, pend_val_d, disp_val_q, disp_val_d;
  logic [DIGITS-1:0]       pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]       anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick, frame_end, digit_on, all_zero;
  logic [DIGITS-1:0]       blank;
  logic [3:0]              nibble;
  logic [6:0]              seg;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    tick      = (pre_q == PreMax);
    frame_end = tick && (idx_q == IdxMax);
    pre_d     = tick ? '0 : pre_q + 1'b1;
    pwm_d     = tick ? '0 : pwm_q + 1'b1;
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    if (load) begin
      pend_val_d = value;
      pend_dp_d  = dp;
    end
    // A load landing on the boundary bypasses pending so it is not lost for a frame.
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    if (frame_end) begin
      disp_val_d = load ? value : pend_val_q;
      disp_dp_d  = load ? dp : pend_dp_q;
    end

    // Blank digit i when it and every more-significant nibble are zero.
    all_zero = 1'b1;
    blank    = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero = all_zero & (disp_val_q[4*i +: 4] == 4'h0);
      blank[i] = blank_leading_zeros & all_zero;
    end

    nibble   = disp_val_q[4*int'(idx_q) +: 4];
    seg      = decode(nibble);
    digit_on = (&brightness) || (pwm_q < brightness);

    anode_d      = digit_on ? ~(DIGITS'(1) << idx_q) : '1;
    cathode_d    = {~disp_dp_q[idx_q], blank[idx_q] ? 7'h7F : seg};
    frame_done_d = frame_end;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      anode_q      <= '1;
      cathode_q    <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign anode      = anode_q;
  assign cathode    = cathode_q;
  assign frame_done = frame_done_q;

endmodule
